// File: rtl/vga_scan_out_pkg.sv
// Shared VGA raster timing defaults, colour/counter types and output-stage record.
// Used by the scan-out block and the sprite renderers that consume its x/y.
package vga_scan_out_pkg;

    localparam int CNT_W = 10;
    localparam int RGB_W = 3;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [RGB_W-1:0] rgb_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        rgb_t rgb;
    } vga_out_t;

    // Idle connector state: syncs deasserted (high), DAC driven black.
    localparam vga_out_t VGA_OUT_IDLE = '{hsync: 1'b1, vsync: 1'b1, rgb: '0};

    function automatic logic in_span(input cnt_t v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

endpackage

// File: rtl/vga_scan_out_pix_div.sv
// Pixel-rate divider: pix_tick_q is high for one clk in every CLK_DIV, glitch-free.
// Latency: first tick is visible after the first rising edge out of reset; no backpressure.
module vga_pix_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic pix_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_tick_q, pix_tick_d;

    // The tick flop follows the next divider value so it is high exactly while div_q == DIV_LAST.
    always_comb begin
        div_d      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        pix_tick_d = (div_d == DIV_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            pix_tick_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            pix_tick_q <= pix_tick_d;
        end
    end

    assign pix_tick = pix_tick_q;

endmodule

// File: rtl/vga_scan_out.sv
// Raster counters, sync decode and blanked sprite-over-background compositing for the VGA port.
// Latency: hsync/vsync/rgb lag x/y by one pixel; free-running, no backpressure.
module vga_scan_out
    import vga_scan_out_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    input  logic [RGB_W-1:0] tp_rgb,
    input  logic             tp_valid,
    input  logic [RGB_W-1:0] bg_rgb,
    output logic             pix_tick,
    output logic             frame_tick,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] rgb
);

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_totals
        $error("vga_scan_out: H_TOTAL/V_TOTAL do not fit the 10-bit raster counters");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_scan_out: CLK_DIV must be at least 1");
    end

    cnt_t     h_cnt_q, h_cnt_d;
    cnt_t     v_cnt_q, v_cnt_d;
    vga_out_t out_q, out_d;
    logic     h_last, v_last, visible;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk      (clk),
        .rst      (rst),
        .pix_tick (pix_tick)
    );

    always_comb begin
        h_last  = (h_cnt_q == H_LAST);
        v_last  = (v_cnt_q == V_LAST);
        visible = (int'(h_cnt_q) < H_VISIBLE) && (int'(v_cnt_q) < V_VISIBLE);
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        out_d   = out_q;
        if (pix_tick) begin
            h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
            if (h_last) begin
                v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
            end
            out_d.hsync = ~in_span(h_cnt_q, HS_START, HS_END);
            out_d.vsync = ~in_span(v_cnt_q, VS_START, VS_END);
            // Nested ifs keep an undriven tp_rgb out of rgb whenever the sprite is not selected.
            out_d.rgb = '0;
            if (visible) begin
                if (tp_valid) begin
                    out_d.rgb = tp_rgb;
                end else begin
                    out_d.rgb = bg_rgb;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            out_q   <= VGA_OUT_IDLE;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            out_q   <= out_d;
        end
    end

    assign x          = h_cnt_q;
    assign y          = v_cnt_q;
    assign frame_tick = pix_tick & h_last & v_last;
    assign hsync      = out_q.hsync;
    assign vsync      = out_q.vsync;
    assign rgb        = out_q.rgb;

endmodule

// File: tb/tb_vga_scan_out.sv
// Directed-vector bench for vga_scan_out on a shrunken 30x19 raster (CLK_DIV=2),
// plus a CLK_DIV=1 instance checking the constant pixel tick.
module tb_vga_scan_out;

    logic       clk;
    logic       rst;
    logic       tp_valid;
    logic [2:0] tp_rgb;
    logic [2:0] bg_rgb;

    logic [9:0] x, y;
    logic       pix_tick, frame_tick, hsync, vsync;
    logic [2:0] rgb;

    logic [9:0] x1, y1;
    logic       pix1, ft1, hs1, vs1;
    logic [2:0] rgb1;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Small raster: H 16+4+6+4 = 30 (hsync on x 20..25), V 12+2+2+3 = 19 (vsync on y 14..15).
    vga_scan_out #(
        .CLK_DIV(2),
        .H_VISIBLE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y),
        .tp_rgb(tp_rgb), .tp_valid(tp_valid), .bg_rgb(bg_rgb),
        .pix_tick(pix_tick), .frame_tick(frame_tick),
        .hsync(hsync), .vsync(vsync), .rgb(rgb)
    );

    vga_scan_out #(
        .CLK_DIV(1)
    ) dut1 (
        .clk(clk), .rst(rst), .x(x1), .y(y1),
        .tp_rgb(tp_rgb), .tp_valid(tp_valid), .bg_rgb(bg_rgb),
        .pix_tick(pix1), .frame_tick(ft1),
        .hsync(hs1), .vsync(vs1), .rgb(rgb1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, %0d vectors applied", vec_cnt);
        $fatal(1);
    end

    typedef struct {
        int         clk_no;
        logic       tv;
        logic [2:0] tp;
        logic [2:0] bg;
        int         ex;
        int         ey;
        logic       epix;
        logic       ehs;
        logic       evs;
        logic [2:0] ergb;
        logic       eft;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // clk_no counts rising edges since reset release; sampling is on the following falling edge.
    task automatic run_table(input int pass);
        int cur;
        cur = 0;
        foreach (tbl[i]) begin
            tp_valid = tbl[i].tv;
            tp_rgb   = tbl[i].tp;
            bg_rgb   = tbl[i].bg;
            step(tbl[i].clk_no - cur);
            cur = tbl[i].clk_no;
            chk($sformatf("p%0d v%0d x", pass, i), 32'(x), tbl[i].ex);
            chk($sformatf("p%0d v%0d y", pass, i), 32'(y), tbl[i].ey);
            chk($sformatf("p%0d v%0d pix_tick", pass, i), 32'(pix_tick), 32'(tbl[i].epix));
            chk($sformatf("p%0d v%0d hsync", pass, i), 32'(hsync), 32'(tbl[i].ehs));
            chk($sformatf("p%0d v%0d vsync", pass, i), 32'(vsync), 32'(tbl[i].evs));
            chk($sformatf("p%0d v%0d rgb", pass, i), 32'(rgb), 32'(tbl[i].ergb));
            chk($sformatf("p%0d v%0d frame_tick", pass, i), 32'(frame_tick), 32'(tbl[i].eft));
            if (tbl[i].clk_no <= 6) begin
                chk($sformatf("p%0d v%0d div1 pix_tick", pass, i), 32'(pix1), 32'd1);
                chk($sformatf("p%0d v%0d div1 x", pass, i), 32'(x1), tbl[i].clk_no - 1);
            end
        end
    endtask

    initial begin
        int  hs_lo, vs_lo, ft_n, pix_n;
        logic found;

        rst      = 1'b1;
        tp_valid = 1'b0;
        tp_rgb   = 3'b000;
        bg_rgb   = 3'b000;

        //                 clk  tv    tp      bg      x   y  pix  hs    vs    rgb     ft
        tbl.push_back('{   1, 1'b1, 3'b101, 3'b010,  0,  0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0});
        tbl.push_back('{   2, 1'b1, 3'b101, 3'b010,  1,  0, 1'b0, 1'b1, 1'b1, 3'b101, 1'b0});
        tbl.push_back('{   4, 1'b1, 3'b101, 3'b010,  2,  0, 1'b0, 1'b1, 1'b1, 3'b101, 1'b0});
        tbl.push_back('{   6, 1'b0, 3'bxxx, 3'b010,  3,  0, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0});
        tbl.push_back('{  33, 1'b1, 3'b101, 3'b010, 16,  0, 1'b1, 1'b1, 1'b1, 3'b101, 1'b0});
        tbl.push_back('{  34, 1'b1, 3'b101, 3'b010, 17,  0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0});
        tbl.push_back('{  41, 1'b1, 3'b101, 3'b010, 20,  0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0});
        tbl.push_back('{  42, 1'b1, 3'b101, 3'b010, 21,  0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0});
        tbl.push_back('{  52, 1'b1, 3'b101, 3'b010, 26,  0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0});
        tbl.push_back('{  54, 1'b1, 3'b101, 3'b010, 27,  0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0});
        tbl.push_back('{  59, 1'b1, 3'b101, 3'b010, 29,  0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0});
        tbl.push_back('{  60, 1'b1, 3'b110, 3'b010,  0,  1, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0});
        tbl.push_back('{  62, 1'b1, 3'b110, 3'b010,  1,  1, 1'b0, 1'b1, 1'b1, 3'b110, 1'b0});
        tbl.push_back('{ 622, 1'b1, 3'b101, 3'b010, 11, 10, 1'b0, 1'b1, 1'b1, 3'b101, 1'b0});
        tbl.push_back('{ 624, 1'b0, 3'b101, 3'b010, 12, 10, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0});
        tbl.push_back('{ 732, 1'b1, 3'b101, 3'b010,  6, 12, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0});
        tbl.push_back('{ 840, 1'b1, 3'b101, 3'b010,  0, 14, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0});
        tbl.push_back('{ 842, 1'b1, 3'b101, 3'b010,  1, 14, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0});
        tbl.push_back('{ 960, 1'b1, 3'b101, 3'b010,  0, 16, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0});
        tbl.push_back('{ 962, 1'b1, 3'b101, 3'b010,  1, 16, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0});
        tbl.push_back('{1138, 1'b1, 3'b101, 3'b010, 29, 18, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0});
        tbl.push_back('{1139, 1'b1, 3'b101, 3'b010, 29, 18, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1});
        tbl.push_back('{1140, 1'b1, 3'b011, 3'b010,  0,  0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0});
        tbl.push_back('{1142, 1'b1, 3'b011, 3'b010,  1,  0, 1'b0, 1'b1, 1'b1, 3'b011, 1'b0});

        step(3);
        chk("reset x", 32'(x), 32'd0);
        chk("reset y", 32'(y), 32'd0);
        chk("reset pix_tick", 32'(pix_tick), 32'd0);
        chk("reset frame_tick", 32'(frame_tick), 32'd0);
        chk("reset hsync", 32'(hsync), 32'd1);
        chk("reset vsync", 32'(vsync), 32'd1);
        chk("reset rgb", 32'(rgb), 32'd0);
        chk("reset div1 pix_tick", 32'(pix1), 32'd0);

        rst = 1'b0;
        run_table(0);

        // One full frame (1140 clks) from an arbitrary phase: pulse and sync-low counts are fixed.
        hs_lo = 0; vs_lo = 0; ft_n = 0; pix_n = 0;
        for (int k = 0; k < 1140; k++) begin
            step(1);
            if (!hsync)    hs_lo++;
            if (!vsync)    vs_lo++;
            if (frame_tick) ft_n++;
            if (pix_tick)  pix_n++;
        end
        chk("frame frame_tick pulses", 32'(ft_n), 32'd1);
        chk("frame pix_tick count", 32'(pix_n), 32'd570);
        chk("frame hsync low clks", 32'(hs_lo), 32'd228);
        chk("frame vsync low clks", 32'(vs_lo), 32'd120);

        // Reset in the middle of both sync pulses.
        found = 1'b0;
        for (int k = 0; k < 1200 && !found; k++) begin
            step(1);
            if (x == 10'd22 && y == 10'd15) found = 1'b1;
        end
        chk("reach x22 y15", 32'(found), 32'd1);
        if (found) begin
            chk("pre-reset hsync low", 32'(hsync), 32'd0);
            chk("pre-reset vsync low", 32'(vsync), 32'd0);
        end
        rst = 1'b1;
        #1;
        chk("midrst x", 32'(x), 32'd0);
        chk("midrst y", 32'(y), 32'd0);
        chk("midrst hsync", 32'(hsync), 32'd1);
        chk("midrst vsync", 32'(vsync), 32'd1);
        chk("midrst rgb", 32'(rgb), 32'd0);
        chk("midrst pix_tick", 32'(pix_tick), 32'd0);
        step(2);
        chk("midrst held x", 32'(x), 32'd0);
        chk("midrst held hsync", 32'(hsync), 32'd1);
        rst = 1'b0;
        run_table(1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
